// File: rtl/detect_event_monitor.sv
// detect_event_monitor
//   Post-processor for the detect111 sequence detector. Rising edges of
//   `detect` are counted per window of WINDOW clock cycles. Each closed window
//   is offered on a valid/ready port, and a threshold alarm is produced.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   en         1 = monitoring; 0 = idle, and closes a running window early
//   detect     detect111 output, same clock domain
//   win_ready  consumer accepts the held window result
//   win_valid  a window result is held on win_count / win_len
//   win_count  events counted in the closed window (saturating)
//   win_len    cycles in the closed window (WINDOW, or fewer on early close)
//   alarm      events in the current window >= THRESH
//   total_cnt  events since reset (saturating)
//   ovf        sticky: a held result was overwritten before it was accepted
//
// States
//   IDLE | not monitoring; events ignored, alarm low
//   RUN  | window open; timer counts cycles, cur_cnt counts events
module detect_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             detect,
  input  logic             win_ready,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_count,
  output logic [CNT_W-1:0] win_len,
  output logic             alarm,
  output logic [CNT_W-1:0] total_cnt,
  output logic             ovf
);

  localparam int TMR_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic             win_valid_q, win_valid_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q, ovf_d;
  logic             detect_q_q, detect_q_d;

  logic             evt;
  logic             close;
  logic             last_cycle;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] tot_next;
  logic [TMR_W:0]   len_ext;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cur_cnt_d   = cur_cnt_q;
    total_cnt_d = total_cnt_q;
    win_count_d = win_count_q;
    win_len_d   = win_len_q;
    win_valid_d = win_valid_q;
    alarm_d     = alarm_q;
    ovf_d       = ovf_q;
    detect_q_d  = detect;
    close       = 1'b0;

    // A run of consecutive highs is one event.
    evt        = detect & ~detect_q_q;
    last_cycle = (timer_q == TMR_W'(WINDOW - 1));
    cnt_next   = (evt && cur_cnt_q != CNT_MAX) ? cur_cnt_q + CNT_W'(1) : cur_cnt_q;
    tot_next   = (evt && total_cnt_q != CNT_MAX) ? total_cnt_q + CNT_W'(1) : total_cnt_q;
    // Normal close reports timer+1 cycles, early close reports timer.
    len_ext    = {1'b0, timer_q} + (TMR_W + 1)'(en ? 1 : 0);

    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        alarm_d = 1'b0;
        if (en) begin
          state_d   = RUN;
          timer_d   = '0;
          cur_cnt_d = '0;
        end
      end
      RUN: begin
        total_cnt_d = tot_next;
        if (!en || last_cycle) begin
          close     = 1'b1;
          state_d   = en ? RUN : IDLE;
          timer_d   = '0;
          cur_cnt_d = '0;
        end else begin
          timer_d   = timer_q + TMR_W'(1);
          cur_cnt_d = cnt_next;
          alarm_d   = (cnt_next >= CNT_W'(THRESH));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A close on the same edge as a transfer simply reloads the port.
    if (close) begin
      win_valid_d = 1'b1;
      win_count_d = cnt_next;
      win_len_d   = CNT_W'(len_ext);
      alarm_d     = 1'b0;
      if (win_valid_q && !win_ready) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cur_cnt_q   <= '0;
      total_cnt_q <= '0;
      win_count_q <= '0;
      win_len_q   <= '0;
      win_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      ovf_q       <= 1'b0;
      detect_q_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_cnt_q   <= cur_cnt_d;
      total_cnt_q <= total_cnt_d;
      win_count_q <= win_count_d;
      win_len_q   <= win_len_d;
      win_valid_q <= win_valid_d;
      alarm_q     <= alarm_d;
      ovf_q       <= ovf_d;
      detect_q_q  <= detect_q_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_count = win_count_q;
  assign win_len   = win_len_q;
  assign alarm     = alarm_q;
  assign total_cnt = total_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_detect_event_monitor.sv
// Bench for detect_event_monitor: directed windows on a default instance and
// a narrow-counter instance. Expected window results go into queues when the
// closing cycle is issued; monitors pop them on each valid&ready transfer.
module tb_detect_event_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en, detect, win_ready;
  logic       win_valid, alarm, ovf;
  logic [7:0] win_count, win_len, total_cnt;

  logic       en2, det2, rdy2;
  logic       wv2, al2, ovf2;
  logic [1:0] wc2, wl2, tot2;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] len;
  } exp_t;

  exp_t       q1[$];
  logic [3:0] q2[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  detect_event_monitor #(.CNT_W(8), .WINDOW(16), .THRESH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .detect(detect), .win_ready(win_ready),
    .win_valid(win_valid), .win_count(win_count), .win_len(win_len),
    .alarm(alarm), .total_cnt(total_cnt), .ovf(ovf)
  );

  detect_event_monitor #(.CNT_W(2), .WINDOW(32), .THRESH(3)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .detect(det2), .win_ready(rdy2),
    .win_valid(wv2), .win_count(wc2), .win_len(wl2),
    .alarm(al2), .total_cnt(tot2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors sample at the falling edge; valid&ready here means a transfer
  // happens on the coming rising edge.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && win_valid && win_ready) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon1_unexpected: got count %0d len %0d expected no result", win_count, win_len);
      end else begin
        e = q1.pop_front();
        chk("mon1_count", win_count, e.cnt);
        chk("mon1_len", win_len, e.len);
      end
    end
  end

  always @(negedge clk) begin : mon2
    logic [3:0] e;
    if (!rst && wv2 && rdy2) begin
      if (q2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon2_unexpected: got count %0d len %0d expected no result", wc2, wl2);
      end else begin
        e = q2.pop_front();
        chk("mon2_count", wc2, e[3:2]);
        chk("mon2_len", wl2, e[1:0]);
      end
    end
  end

  task automatic cyc(input logic e, input logic d, input logic r);
    en = e;
    detect = d;
    win_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, win_valid, 0);
    chk({tag, "_count"}, win_count, 0);
    chk({tag, "_len"}, win_len, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_total"}, total_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  // Called at posedge+1; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    en = 1'b0;
    detect = 1'b0;
    rst = 1'b1;
    #2;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    en = 1'b0; detect = 1'b0; win_ready = 1'b1;
    en2 = 1'b0; det2 = 1'b0; rdy2 = 1'b1;
    @(posedge clk);
    #1;
    do_reset("rst0");
    chk("rst0_total2", tot2, 0);
    chk("rst0_valid2", wv2, 0);

    // 1: pulses at timer 2, 6, 10 -> 3 events, full window of 16.
    cyc(1, 0, 1);
    for (int t = 0; t < 16; t++) begin
      if (t == 15) q1.push_back('{cnt: 8'd3, len: 8'd16});
      cyc(1, (t == 2 || t == 6 || t == 10), 1);
      chk("t1_alarm", alarm, (t >= 10 && t < 15) ? 1 : 0);
    end
    chk("t1_valid", win_valid, 1);
    // en dropped at timer 0 of the next window: zero-length early close.
    q1.push_back('{cnt: 8'd0, len: 8'd0});
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("t1_valid_clr", win_valid, 0);
    chk("t1_total", total_cnt, 3);

    // 2: detect held high 5 cycles counts once.
    do_reset("rst2");
    cyc(1, 0, 1);
    for (int t = 0; t < 16; t++) begin
      if (t == 15) q1.push_back('{cnt: 8'd1, len: 8'd16});
      cyc(1, (t >= 1 && t <= 5), 1);
      if (t == 5) begin
        chk("t2_alarm", alarm, 0);
        chk("t2_total_mid", total_cnt, 1);
      end
    end
    chk("t2_total", total_cnt, 1);
    q1.push_back('{cnt: 8'd0, len: 8'd0});
    cyc(0, 0, 1);
    cyc(0, 0, 1);

    // 3: result not accepted across two windows -> overwrite and ovf.
    do_reset("rst3");
    cyc(1, 0, 0);
    for (int t = 0; t < 16; t++) cyc(1, (t == 3), 0);
    chk("t3_valid_a", win_valid, 1);
    chk("t3_count_a", win_count, 1);
    chk("t3_ovf_a", ovf, 0);
    for (int t = 0; t < 16; t++) cyc(1, (t == 4 || t == 8), 0);
    chk("t3_ovf", ovf, 1);
    chk("t3_valid_b", win_valid, 1);
    chk("t3_count_b", win_count, 2);
    chk("t3_len_b", win_len, 16);
    q1.push_back('{cnt: 8'd2, len: 8'd16});
    cyc(1, 0, 1);
    chk("t3_valid_clr", win_valid, 0);
    chk("t3_ovf_hold", ovf, 1);

    // 6: reset mid-window with cur_cnt=2 and ovf=1.
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t6_alarm_pre", alarm, 0);
    chk("t6_total_pre", total_cnt, 5);
    do_reset("t6_rst");
    cyc(1, 0, 1);
    for (int t = 0; t < 16; t++) begin
      if (t == 15) q1.push_back('{cnt: 8'd1, len: 8'd16});
      cyc(1, (t == 0), 1);
    end
    chk("t6_total", total_cnt, 1);

    // 4: window restarts immediately; 6 RUN cycles with 2 events, then en=0.
    for (int t = 0; t < 6; t++) cyc(1, (t == 1 || t == 4), 1);
    q1.push_back('{cnt: 8'd2, len: 8'd6});
    cyc(0, 0, 1);
    chk("t4_valid", win_valid, 1);
    chk("t4_total", total_cnt, 3);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    chk("t4_total_idle", total_cnt, 3);
    chk("t4_valid_clr", win_valid, 0);
    chk("t4_alarm_idle", alarm, 0);

    // 5: CNT_W=2, WINDOW=32, 6 pulses -> counts saturate at 3;
    // win_len of 32 wraps to 0 in a 2-bit field.
    en2 = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t < 32; t++) begin
      det2 = (t % 2 == 1 && t < 12);
      if (t == 31) q2.push_back({2'd3, 2'd0});
      @(posedge clk);
      #1;
      if (t == 5) chk("t5_alarm", al2, 1);
      if (t == 3) chk("t5_alarm_lo", al2, 0);
    end
    det2 = 1'b0;
    chk("t5_total", tot2, 3);
    chk("t5_valid", wv2, 1);
    en2 = 1'b0;
    q2.push_back({2'd0, 2'd0});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t5_valid_clr", wv2, 0);

    @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
